// File: rtl/rtc_port_bridge.sv
// rtc_port_bridge: PicoBlaze I/O-port bridge to a multiplexed-bus RTC.
// Single writes and burst reads; read data is queued in a FIFO for the micro.
module rtc_port_bridge #(
    parameter logic [7:0] BASE_PORT = 8'h10,
    parameter int         T_PH      = 2,
    parameter int         DEPTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] dato_in,
    input  logic       writestrobe,
    input  logic       readstrobe,
    output logic [7:0] data_out_micro,
    output logic       irq,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] P_ADDR = BASE_PORT;
    localparam logic [7:0] P_WD   = BASE_PORT + 8'd1;
    localparam logic [7:0] P_RD   = BASE_PORT + 8'd2;
    localparam logic [7:0] P_CTL  = BASE_PORT + 8'd3;
    localparam logic [7:0] P_FIFO = BASE_PORT + 8'd4;
    localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

    typedef enum logic [2:0] {IDLE, A_STB, A_HLD, D_STB, D_HLD, DONE} state_t;

    state_t      st, st_n;
    logic [3:0]  ph, ph_n;
    logic [7:0]  addr, wdata, wdata_n, cur, cur_n;
    logic [4:0]  rem, rem_n;
    logic        rd, rd_n, irq_en, err, busy, last;
    logic        launch_w, launch_r, reject, go, push, pop, flush, full, empty, a_ph, d_ph;
    logic [AW:0] wp, rp, cnt;
    logic [5:0]  free;
    logic [7:0]  mem [DEPTH];

    assign busy     = st != IDLE;
    assign last     = ph == PH_LAST;
    assign cnt      = wp - rp;
    assign full     = cnt[AW];
    assign empty    = wp == rp;
    assign free     = 6'(DEPTH) - 6'(cnt);
    assign launch_w = writestrobe && port_id == P_WD;
    assign launch_r = writestrobe && port_id == P_RD;
    assign reject   = (launch_w || launch_r) &&
                      (busy || (launch_r && (dato_in[4:0] == 5'd0 || {1'b0, dato_in[4:0]} > free)));
    assign go       = (launch_w || launch_r) && !reject;
    assign push     = st == D_STB && last && rd;
    assign pop      = readstrobe && port_id == P_FIFO && !empty;
    assign flush    = writestrobe && port_id == P_CTL && dato_in[2];
    assign wdata_n  = go && launch_w ? dato_in : wdata;
    assign a_ph     = st_n == A_STB || st_n == A_HLD;
    assign d_ph     = st_n == D_STB || st_n == D_HLD;

    assign data_out_micro = port_id == P_CTL ? {3'b000, irq_en, err, full, empty, busy} :
                            port_id == P_FIFO && !empty ? mem[rp[AW-1:0]] : 8'h00;

    always_comb begin
        st_n  = st;
        ph_n  = last ? 4'd0 : ph + 4'd1;
        rd_n  = rd;
        cur_n = cur;
        rem_n = rem;
        case (st)
            IDLE: begin
                ph_n = 4'd0;
                if (go) begin
                    st_n  = A_STB;
                    rd_n  = launch_r;
                    cur_n = addr;
                    rem_n = launch_r ? dato_in[4:0] : 5'd1;
                end
            end
            A_STB: st_n = last ? A_HLD : A_STB;
            A_HLD: st_n = last ? D_STB : A_HLD;
            D_STB: st_n = last ? D_HLD : D_STB;
            D_HLD: if (last) begin
                // burst continues on the next address; the addr register stays untouched
                if (rd && rem > 5'd1) begin
                    st_n  = A_STB;
                    rem_n = rem - 5'd1;
                    cur_n = cur + 8'd1;
                end else begin
                    st_n = DONE;
                end
            end
            DONE: begin
                st_n = IDLE;
                ph_n = 4'd0;
            end
            default: st_n = IDLE;
        endcase
    end

    // bus outputs are registered from the next state so they change cleanly on the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            ph     <= 4'd0;
            rd     <= 1'b0;
            cur    <= 8'h00;
            rem    <= 5'd0;
            addr   <= 8'h00;
            wdata  <= 8'h00;
            irq_en <= 1'b0;
            err    <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            CS     <= 1'b1;
            AD     <= 1'b1;
            RD     <= 1'b1;
            WR     <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
            irq    <= 1'b0;
        end else begin
            st     <= st_n;
            ph     <= ph_n;
            rd     <= rd_n;
            cur    <= cur_n;
            rem    <= rem_n;
            wdata  <= wdata_n;
            addr   <= writestrobe && port_id == P_ADDR ? dato_in : addr;
            irq_en <= writestrobe && port_id == P_CTL ? dato_in[0] : irq_en;
            err    <= reject || (err && !(writestrobe && port_id == P_CTL && dato_in[1]));
            wp     <= wp + {{AW{1'b0}}, push};
            rp     <= flush ? wp : rp + {{AW{1'b0}}, pop};
            CS     <= !(a_ph || d_ph);
            AD     <= !a_ph;
            WR     <= !(st_n == A_STB || (st_n == D_STB && !rd_n));
            RD     <= !(st_n == D_STB && rd_n);
            ad_oe  <= a_ph || (d_ph && !rd_n);
            ad_out <= a_ph ? cur_n : d_ph && !rd_n ? wdata_n : 8'h00;
            irq    <= st_n == DONE && irq_en;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= ad_in;
    end
endmodule

// File: tb/tb_rtc_port_bridge.sv
// tb_rtc_port_bridge: randomized scenario bench for rtc_port_bridge (T_PH=2, DEPTH=8, BASE=8'h10).
module tb_rtc_port_bridge;
    localparam logic [7:0] P_ADDR = 8'h10, P_WD = 8'h11, P_RD = 8'h12, P_CTL = 8'h13, P_FIFO = 8'h14;
    localparam int T = 2;
    localparam int CYC = 4 * T;

    logic       clk = 1'b0, reset = 1'b1, writestrobe = 1'b0, readstrobe = 1'b0;
    logic [7:0] port_id = 8'h00, dato_in = 8'h00, lat = 8'h00;
    logic [7:0] data_out_micro, ad_out, ad_in;
    logic       irq, CS, AD, RD, WR, ad_oe;
    int         vec = 0, errs = 0;
    logic [7:0] q[$];
    bit         ien_m = 1'b0, err_m = 1'b0;

    always #5 clk = ~clk;

    // RTC model: answers each read with the address it was given plus 8'h40
    always @(posedge clk) if (!CS && !AD) lat <= ad_out;
    assign ad_in = lat + 8'h40;

    rtc_port_bridge #(.BASE_PORT(8'h10), .T_PH(T), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .dato_in(dato_in),
        .writestrobe(writestrobe), .readstrobe(readstrobe), .data_out_micro(data_out_micro),
        .irq(irq), .CS(CS), .AD(AD), .RD(RD), .WR(WR), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    function automatic logic [7:0] status_m(input bit b);
        return {3'b000, ien_m, err_m, q.size() == 8, q.size() == 0, b};
    endfunction

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p;
        dato_in = d;
        writestrobe = 1'b1;
        @(posedge clk);
        #1 writestrobe = 1'b0;
    endtask

    task automatic pop(output logic [7:0] v);
        port_id = P_FIFO;
        readstrobe = 1'b1;
        #1 v = data_out_micro;
        @(posedge clk);
        #1 readstrobe = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        port_id = P_CTL;
        cyc = 0;
        @(negedge clk);
        while (data_out_micro[0] && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        port_id = P_CTL;
        #1 vec++;
        if ({CS, AD, WR, RD, ad_oe, ad_out, irq, data_out_micro} !== {5'b11110, 8'h00, 1'b0, 8'h02}) begin
            errs++;
            $display("FAIL reset_held got=%b exp=%b", {CS, AD, WR, RD, ad_oe, ad_out, irq, data_out_micro},
                     {5'b11110, 8'h00, 1'b0, 8'h02});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({CS, AD, WR, RD, ad_oe, irq, data_out_micro} !== {5'b11110, 1'b0, status_m(0)}) begin
            errs++;
            $display("FAIL reset_released got=%b exp=%b", {CS, AD, WR, RD, ad_oe, irq, data_out_micro},
                     {5'b11110, 1'b0, status_m(0)});
        end
        port_id = P_FIFO;
        #1 vec++;
        if (data_out_micro !== 8'h00) begin
            errs++;
            $display("FAIL reset_fifo_port got=%h exp=00", data_out_micro);
        end
    endtask

    task automatic test_bus_cycle(input bit rdb, input logic [7:0] a, input logic [7:0] v);
        int n, tot, r, p;
        logic [14:0] exp, got, msk;
        n = rdb ? int'(v[4:0]) : 1;
        tot = CYC * n;
        wr(P_ADDR, a);
        wr(rdb ? P_RD : P_WD, v);
        port_id = P_CTL;
        for (int j = 0; j <= tot + 1; j++) begin
            @(negedge clk);
            r = j / CYC;
            p = (j % CYC) / T;
            if (j < tot) begin
                exp[14]   = 1'b0;
                exp[13]   = p >= 2;
                exp[12]   = !(p == 0 || (p == 2 && !rdb));
                exp[11]   = !(p == 2 && rdb);
                exp[10]   = p < 2 || !rdb;
                exp[9:2]  = p < 2 ? a + 8'(r) : v;
                exp[1]    = 1'b1;
                exp[0]    = 1'b0;
            end else begin
                exp = {5'b11110, 8'h00, j == tot, j == tot && ien_m};
            end
            msk = exp[10] ? 15'h7FFF : 15'h7C03;
            got = {CS, AD, WR, RD, ad_oe, ad_out, data_out_micro[0], irq};
            vec++;
            if ((got & msk) !== (exp & msk)) begin
                errs++;
                $display("FAIL bus_%s j=%0d got=%b exp=%b", rdb ? "read" : "write", j, got & msk, exp & msk);
            end
        end
        if (rdb) for (int i = 0; i < n; i++) q.push_back(a + 8'(i) + 8'h40);
    endtask

    task automatic test_write();
        test_bus_cycle(1'b0, 8'h0B, 8'h59);
        repeat (3) test_bus_cycle(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_burst();
        logic [7:0] v, e;
        test_bus_cycle(1'b1, 8'hFE, 8'd3);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) test_bus_cycle(1'b1, 8'($urandom), 8'($urandom_range(1, 8)));
            while (q.size() > 0) begin
                pop(v);
                e = q.pop_front();
                vec++;
                if (v !== e) begin
                    errs++;
                    $display("FAIL burst_pop got=%h exp=%h", v, e);
                end
            end
            port_id = P_CTL;
            #1 vec++;
            if (data_out_micro !== status_m(0)) begin
                errs++;
                $display("FAIL burst_status got=%h exp=%h", data_out_micro, status_m(0));
            end
        end
    endtask

    task automatic test_error();
        int c;
        logic [7:0] d;
        d = 8'($urandom);
        wr(P_ADDR, 8'($urandom));
        wr(P_WD, d);
        wr(P_WD, ~d);
        err_m = 1'b1;
        wait_idle(c);
        vec++;
        if (c !== 8) begin
            errs++;
            $display("FAIL busy_launch_len got=%0d exp=8", c);
        end
        #1 vec++;
        if (data_out_micro !== status_m(0)) begin
            errs++;
            $display("FAIL err_set got=%h exp=%h", data_out_micro, status_m(0));
        end
        wr(P_RD, 8'd0);
        port_id = P_CTL;
        @(negedge clk);
        vec++;
        if ({CS, data_out_micro} !== {1'b1, status_m(0)}) begin
            errs++;
            $display("FAIL n_zero got=%b exp=%b", {CS, data_out_micro}, {1'b1, status_m(0)});
        end
        wr(P_CTL, 8'h02);
        err_m = 1'b0;
        ien_m = 1'b0;
        port_id = P_CTL;
        #1 vec++;
        if (data_out_micro !== status_m(0)) begin
            errs++;
            $display("FAIL err_clear got=%h exp=%h", data_out_micro, status_m(0));
        end
    endtask

    task automatic test_irq();
        logic [7:0] v, e;
        wr(P_CTL, 8'h01);
        ien_m = 1'b1;
        test_bus_cycle(1'b1, 8'($urandom), 8'd1);
        wr(P_CTL, 8'h00);
        ien_m = 1'b0;
        test_bus_cycle(1'b1, 8'($urandom), 8'd1);
        while (q.size() > 0) begin
            pop(v);
            e = q.pop_front();
            vec++;
            if (v !== e) begin
                errs++;
                $display("FAIL irq_pop got=%h exp=%h", v, e);
            end
        end
    endtask

    task automatic test_fifo();
        int c;
        logic [7:0] v, e, b;
        test_bus_cycle(1'b1, 8'($urandom), 8'd8);
        port_id = P_CTL;
        #1 vec++;
        if (data_out_micro !== status_m(0)) begin
            errs++;
            $display("FAIL fifo_full got=%h exp=%h", data_out_micro, status_m(0));
        end
        wr(P_RD, 8'd1);
        err_m = 1'b1;
        port_id = P_CTL;
        @(negedge clk);
        vec++;
        if ({CS, data_out_micro} !== {1'b1, status_m(0)}) begin
            errs++;
            $display("FAIL full_reject got=%b exp=%b", {CS, data_out_micro}, {1'b1, status_m(0)});
        end
        wr(P_CTL, 8'h02);
        err_m = 1'b0;
        pop(v);
        e = q.pop_front();
        vec++;
        if (v !== e) begin
            errs++;
            $display("FAIL fifo_pop1 got=%h exp=%h", v, e);
        end
        b = 8'($urandom);
        wr(P_ADDR, b);
        wr(P_RD, 8'd1);
        repeat (5) @(posedge clk);
        #1 port_id = P_FIFO;
        readstrobe = 1'b1;
        #1 vec++;
        if (data_out_micro !== q[0]) begin
            errs++;
            $display("FAIL pop_push_head got=%h exp=%h", data_out_micro, q[0]);
        end
        @(posedge clk);
        #1 readstrobe = 1'b0;
        void'(q.pop_front());
        q.push_back(b + 8'h40);
        wait_idle(c);
        #1 vec++;
        if (c >= 200 || data_out_micro !== status_m(0)) begin
            errs++;
            $display("FAIL pop_push_status cyc=%0d got=%h exp=%h", c, data_out_micro, status_m(0));
        end
        while (q.size() > 0) begin
            pop(v);
            e = q.pop_front();
            vec++;
            if (v !== e) begin
                errs++;
                $display("FAIL fifo_drain got=%h exp=%h", v, e);
            end
        end
        pop(v);
        port_id = P_CTL;
        #1 vec++;
        if ({v, data_out_micro} !== {8'h00, status_m(0)}) begin
            errs++;
            $display("FAIL empty_pop got=%h exp=%h", {v, data_out_micro}, {8'h00, status_m(0)});
        end
    endtask

    task automatic test_flush();
        int c;
        logic [7:0] v, e, a;
        a = 8'($urandom);
        wr(P_ADDR, a);
        wr(P_RD, 8'd4);
        repeat (15) @(posedge clk);
        #1 wr(P_CTL, 8'h04);
        for (int i = 2; i < 4; i++) q.push_back(a + 8'(i) + 8'h40);
        wait_idle(c);
        vec++;
        if (c >= 200) begin
            errs++;
            $display("FAIL flush_timeout got=%0d exp=<200", c);
        end
        while (q.size() > 0) begin
            pop(v);
            e = q.pop_front();
            vec++;
            if (v !== e) begin
                errs++;
                $display("FAIL flush_pop got=%h exp=%h", v, e);
            end
        end
        port_id = P_CTL;
        #1 vec++;
        if (data_out_micro !== status_m(0)) begin
            errs++;
            $display("FAIL flush_status got=%h exp=%h", data_out_micro, status_m(0));
        end
    endtask

    task automatic test_reset_mid();
        wr(P_ADDR, 8'($urandom));
        wr(P_RD, 8'd2);
        port_id = P_CTL;
        repeat (4) @(posedge clk);
        #1 vec++;
        if ({CS, RD} !== 2'b00) begin
            errs++;
            $display("FAIL pre_reset_dstb got=%b exp=00", {CS, RD});
        end
        #1 reset = 1'b1;
        q.delete();
        ien_m = 1'b0;
        err_m = 1'b0;
        #1 vec++;
        if ({CS, AD, WR, RD, ad_oe, ad_out, irq, data_out_micro} !== {5'b11110, 8'h00, 1'b0, status_m(0)}) begin
            errs++;
            $display("FAIL mid_reset got=%b exp=%b", {CS, AD, WR, RD, ad_oe, ad_out, irq, data_out_micro},
                     {5'b11110, 8'h00, 1'b0, status_m(0)});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        test_bus_cycle(1'b0, 8'h0B, 8'h59);
    endtask

    initial begin
        test_reset();
        test_write();
        test_burst();
        test_error();
        test_irq();
        test_fifo();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
